l2_mem_responder: RTL and testbench
===================================

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 Parameter XLEN, default 32: data/address width in bits.
REQ-002 Parameter NUM_WORDS, default 2048: backing-store depth in XLEN words; power of two.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to fulfilment; legal range 1..255.
REQ-004 Parameter DEFAULT_VALUE, default 32'hACAB_0012: word returned for never-written locations.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 l2_req_address  input  XLEN  byte address of the request.
REQ-008 l2_req_type  input  memory_operation_e  LOAD, STORE or other.
REQ-009 l2_req_valid  input  1  request present; held with stable fields until fulfilled.
REQ-010 l2_word_to_store  input  XLEN  store data.
REQ-011 l2_fetched_word  output  XLEN  load data; valid while l2_req_fulfilled=1.
REQ-012 l2_req_fulfilled  output  1  one-cycle completion pulse, registered.
REQ-013 l2_protocol_error  output  1  sticky flag: a request with a type other than LOAD or STORE was accepted.

Function
REQ-014 States: IDLE, WAIT, RESPOND.
  - IDLE -> WAIT on a rising edge with l2_req_valid=1; address, type and store data are captured at that edge.
  - WAIT -> RESPOND when the latency counter expires.
  - RESPOND -> IDLE unconditionally.
REQ-015 Acceptance edge E0: counter loads LATENCY-1. In WAIT the counter decrements each edge, and the exit to RESPOND occurs at edge E0+LATENCY, so l2_req_fulfilled is high between edges E0+LATENCY and E0+LATENCY+1. When LATENCY=1, the transition is IDLE->WAIT->RESPOND with the counter already at 0.
REQ-016 l2_req_fulfilled is high in RESPOND only; it is exactly one cycle wide.
REQ-017 Word index = captured address bits [2 +: log2(NUM_WORDS)]. Byte-offset bits [1:0] are ignored. Upper bits are ignored, so addresses alias modulo NUM_WORDS*4.
REQ-018 LOAD: l2_fetched_word is registered at edge E0+LATENCY with the array word. DEFAULT_VALUE is returned if that word's written bit is clear.
REQ-019 STORE: the captured data is written to the array and the word's written bit is set at edge E0+LATENCY. l2_fetched_word is unchanged.
REQ-020 Other type: fulfilled as normal; no array write; l2_fetched_word unchanged; l2_protocol_error set at E0+LATENCY.
REQ-021 Since the initiator still holds the old request at edge E0+LATENCY+1, no request is accepted at that edge. The earliest next acceptance is edge E0+LATENCY+2, giving a throughput of one request per LATENCY+2 cycles.
REQ-022 Input changes during WAIT/RESPOND are ignored; captured values govern the transaction.
REQ-023 l2_req_valid low in IDLE: stay in IDLE, no side effects.
REQ-024 A LOAD following a STORE to the same word returns the stored data. Full-word stores only; no byte masking.

Reset
REQ-025 While reset=1 at a rising edge:
  - state <= IDLE, counter <= 0
  - l2_req_fulfilled <= 0, l2_fetched_word <= 0, l2_protocol_error <= 0
  - all written bits cleared
REQ-026 Reset asserted mid-transaction aborts it. No fulfilment pulse is produced and a pending STORE is not committed.
REQ-027 Array data contents need no reset; the cleared written bits make every word read as DEFAULT_VALUE.

Structure
REQ-028 memory_operation_e is used from xentry_pkg. The responder state enum (l2_responder_state_e) is added to xentry_pkg.
REQ-029 Storage is sub-module l2_mem_array, containing:
  - NUM_WORDS x XLEN data
  - a per-word written-bit vector with synchronous clear
  - one synchronous read/write port with DEFAULT_VALUE substitution on read

Verification
REQ-030 Load of an unwritten address 0x0000_0100 with LATENCY=2 -> fulfilled high exactly in cycle 2 after acceptance for one cycle; fetched word 32'hACAB_0012.
REQ-031 STORE 32'hFEED_BEEF to 0x0000_0040, then LOAD 0x0000_0043 -> 32'hFEED_BEEF; separately, LOAD 0x0000_2040 (alias with NUM_WORDS=2048) -> 32'hFEED_BEEF.
REQ-032 Valid held high continuously across back-to-back LOADs -> one pulse per request, pulses separated by LATENCY+1 low cycles, no duplicate service.
REQ-033 Reset asserted during WAIT of a STORE of 32'h1234_5678 to 0x80 -> no pulse; a later LOAD of 0x80 returns 32'hACAB_0012.
REQ-034 CLFLUSH-type request -> fulfilled pulse, l2_protocol_error=1 and sticky until reset, array contents unchanged.
REQ-035 LATENCY=1 and LATENCY=7 builds -> acceptance-to-pulse distance of 1 and 7 cycles respectively.

Source files
------------

// File: rtl/xentry_pkg.sv
// ---------------------------------------------------------------------------
// xentry_pkg
// Shared types for the L2 memory responder slice.
//   memory_operation_e   : request opcode presented by the initiator
//   l2_responder_state_e : responder controller state
//   is_legal_op()        : true for the opcodes the responder actually serves
// ---------------------------------------------------------------------------
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        STORE   = 2'd1,
        CLFLUSH = 2'd2,
        FENCE   = 2'd3
    } memory_operation_e;

    typedef enum logic [1:0] {
        L2_IDLE    = 2'd0,
        L2_WAIT    = 2'd1,
        L2_RESPOND = 2'd2
    } l2_responder_state_e;

    // Latency counter width; covers LATENCY up to 255.
    localparam int unsigned L2_CNT_W = 8;

    function automatic logic is_legal_op(input memory_operation_e op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/l2_mem_array.sv
// ---------------------------------------------------------------------------
// l2_mem_array
// NUM_WORDS x XLEN backing store with one synchronous read/write port.
// A per-word "written" bit (synchronously cleared) tracks which words have
// ever been stored; reads of unwritten words return DEFAULT_VALUE, so the
// data array itself never needs a reset.
// Ports:
//   clk    : clock
//   srst   : synchronous active-high reset (clears written bits, read reg)
//   en     : perform an access this edge
//   we     : 1 = write wdata, 0 = read into rdata
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data, holds its value between reads
// ---------------------------------------------------------------------------
module l2_mem_array #(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     NUM_WORDS     = 2048,
    parameter int unsigned     AW            = $clog2(NUM_WORDS),
    parameter logic [XLEN-1:0] DEFAULT_VALUE = 32'hACAB_0012
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0]      r_mem [NUM_WORDS];
    logic [NUM_WORDS-1:0] r_written;
    logic [XLEN-1:0]      r_rdata;

    // Data array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_written <= '0;
            r_rdata   <= '0;
        end else if (en) begin
            if (we) begin
                r_written[addr] <= 1'b1;
            end else begin
                r_rdata <= r_written[addr] ? r_mem[addr] : DEFAULT_VALUE;
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// ---------------------------------------------------------------------------
// l2_mem_responder
// Fixed-latency L2 memory model. A request is captured on the edge where it
// is seen in IDLE, served LATENCY edges later, and acknowledged with a
// one-cycle l2_req_fulfilled pulse.
// Ports:
//   clk                : clock
//   reset              : synchronous active-high reset
//   l2_req_address     : byte address (word index = bits [2 +: log2(NUM_WORDS)])
//   l2_req_type        : LOAD / STORE / other
//   l2_req_valid       : request present
//   l2_word_to_store   : store data
//   l2_fetched_word    : load data, valid while l2_req_fulfilled is high
//   l2_req_fulfilled   : one-cycle completion pulse
//   l2_protocol_error  : sticky, set when a non LOAD/STORE request completes
// ---------------------------------------------------------------------------
module l2_mem_responder
    import xentry_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     NUM_WORDS     = 2048,
    parameter int unsigned     LATENCY       = 2,
    parameter logic [XLEN-1:0] DEFAULT_VALUE = 32'hACAB_0012
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   l2_req_address,
    input  memory_operation_e l2_req_type,
    input  logic              l2_req_valid,
    input  logic [XLEN-1:0]   l2_word_to_store,
    output logic [XLEN-1:0]   l2_fetched_word,
    output logic              l2_req_fulfilled,
    output logic              l2_protocol_error
);

    localparam int unsigned         AW       = $clog2(NUM_WORDS);
    localparam logic [L2_CNT_W-1:0] CNT_LOAD = L2_CNT_W'(LATENCY - 1);

    l2_responder_state_e   r_state;
    logic [L2_CNT_W-1:0]   r_cnt;
    logic [AW-1:0]         r_idx;
    memory_operation_e     r_type;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_fulfilled;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_access;
    logic [XLEN-1:0]       w_rdata;
    logic                  w_unused_addr;

    // Byte offset and aliasing upper bits play no part in the lookup.
    assign w_unused_addr = ^{l2_req_address[XLEN-1:AW+2], l2_req_address[1:0]};

    assign w_accept = (r_state == L2_IDLE) && l2_req_valid;
    // Service edge: last WAIT cycle. Gated by reset so an aborted STORE
    // never touches the array.
    assign w_commit = (r_state == L2_WAIT) && (r_cnt == '0) && !reset;
    assign w_access = w_commit && is_legal_op(r_type);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= L2_IDLE;
            r_cnt       <= '0;
            r_fulfilled <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fulfilled <= 1'b0;
            case (r_state)
                L2_IDLE: begin
                    if (l2_req_valid) begin
                        r_state <= L2_WAIT;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                L2_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= L2_RESPOND;
                        r_fulfilled <= 1'b1;
                        if (!is_legal_op(r_type)) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // The initiator still drives the old request here; going
                // straight to IDLE without sampling avoids double service.
                L2_RESPOND: r_state <= L2_IDLE;
                default:    r_state <= L2_IDLE;
            endcase
        end
    end

    // Request capture; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= l2_req_address[2 +: AW];
            r_type  <= l2_req_type;
            r_wdata <= l2_word_to_store;
        end
    end

    l2_mem_array #(
        .XLEN          (XLEN),
        .NUM_WORDS     (NUM_WORDS),
        .AW            (AW),
        .DEFAULT_VALUE (DEFAULT_VALUE)
    ) u_array (
        .clk   (clk),
        .srst  (reset),
        .en    (w_access),
        .we    (r_type == STORE),
        .addr  (r_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign l2_fetched_word   = w_rdata;
    assign l2_req_fulfilled  = r_fulfilled;
    assign l2_protocol_error = r_err;

endmodule

// File: tb/tb_l2_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_l2_mem_responder
// Three responders (LATENCY 1, 2, 7). Instance 1 (LATENCY 2) is compared
// every cycle against a schedule-based reference model and gets directed
// plus randomized traffic; instances 0 and 2 get directed latency checks.
// ---------------------------------------------------------------------------
module tb_l2_mem_responder;
    import xentry_pkg::*;

    localparam logic [31:0] DEF       = 32'hACAB_0012;
    localparam int          MODEL_LAT = 2;

    logic              clk;
    logic              reset;
    logic              valid_v     [3];
    memory_operation_e type_v      [3];
    logic [31:0]       addr_v      [3];
    logic [31:0]       data_v      [3];
    logic [31:0]       fetched_v   [3];
    logic              fulfilled_v [3];
    logic              err_v       [3];

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        l2_mem_responder #(
            .XLEN          (32),
            .NUM_WORDS     (2048),
            .LATENCY       ((gi == 0) ? 1 : ((gi == 1) ? 2 : 7)),
            .DEFAULT_VALUE (DEF)
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .l2_req_address    (addr_v[gi]),
            .l2_req_type       (type_v[gi]),
            .l2_req_valid      (valid_v[gi]),
            .l2_word_to_store  (data_v[gi]),
            .l2_fetched_word   (fetched_v[gi]),
            .l2_req_fulfilled  (fulfilled_v[gi]),
            .l2_protocol_error (err_v[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model for instance 1 ----------------------
    // Works purely on edge numbers: a request seen at edge E (when allowed)
    // completes at E+LAT, and the next one may be taken at E+LAT+2.
    int                unsigned cyc = 0;
    int                unsigned next_accept = 0;
    int                unsigned pulse_edge = 0;
    bit                pending = 0;
    memory_operation_e cap_type;
    int                cap_idx;
    logic [31:0]       cap_data;
    logic [31:0]       model_mem [int];
    logic              exp_ful = 1'b0;
    logic              exp_err = 1'b0;
    logic [31:0]       exp_fetch = '0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pending = 0;
                model_mem.delete();
                exp_ful = 1'b0;
                exp_err = 1'b0;
                exp_fetch = '0;
                next_accept = cyc + 1;
            end else begin
                exp_ful = 1'b0;
                if (pending && cyc == pulse_edge) begin
                    pending = 0;
                    exp_ful = 1'b1;
                    if (cap_type == LOAD)
                        exp_fetch = model_mem.exists(cap_idx) ? model_mem[cap_idx] : DEF;
                    else if (cap_type == STORE)
                        model_mem[cap_idx] = cap_data;
                    else
                        exp_err = 1'b1;
                end else if (!pending && valid_v[1] && cyc >= next_accept) begin
                    pending = 1;
                    pulse_edge = cyc + MODEL_LAT;
                    next_accept = cyc + MODEL_LAT + 2;
                    cap_type = type_v[1];
                    cap_idx = int'(addr_v[1][12:2]);
                    cap_data = data_v[1];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("cyc_fulfilled", {31'b0, fulfilled_v[1]}, {31'b0, exp_ful});
                check("cyc_protocol_error", {31'b0, err_v[1]}, {31'b0, exp_err});
                check("cyc_fetched_word", fetched_v[1], exp_fetch);
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    // Called #1 after a rising edge. Returns edges until the pulse was seen
    // and the word present during the pulse, then holds the request one
    // more edge (as a real initiator would) and checks the pulse ended.
    task automatic run_txn(input int inst, input string name, input memory_operation_e op,
                           input logic [31:0] a, input logic [31:0] d,
                           output int n, output logic [31:0] fw, output logic er);
        bit got = 0;
        valid_v[inst] = 1'b1;
        type_v[inst]  = op;
        addr_v[inst]  = a;
        data_v[inst]  = d;
        n = 0;
        fw = '0;
        er = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (fulfilled_v[inst]) got = 1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no fulfil pulse within 40 cycles, required one", name);
        end else begin
            fw = fetched_v[inst];
            er = err_v[inst];
            $display("txn inst%0d %s op=%s addr=%h data=%h edges=%0d fetched=%h err=%0d",
                     inst, name, op.name(), a, d, n, fw, er);
            @(posedge clk); #1;
            check({name, "_pulse_width"}, {31'b0, fulfilled_v[inst]}, 32'd0);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin
        int          n;
        logic [31:0] fw;
        logic        er;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_v[i] = 1'b0;
            type_v[i]  = LOAD;
            addr_v[i]  = '0;
            data_v[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1;

        for (int i = 0; i < 3; i++) begin
            check("reset_fulfilled", {31'b0, fulfilled_v[i]}, 32'd0);
            check("reset_fetched", fetched_v[i], 32'd0);
            check("reset_protocol_error", {31'b0, err_v[i]}, 32'd0);
        end

        // Unwritten load, LATENCY 2: pulse two edges after acceptance.
        run_txn(1, "load_unwritten", LOAD, 32'h0000_0100, 32'h0, n, fw, er);
        check("load_unwritten_distance", n - 1, 32'd2);
        check("load_unwritten_data", fw, 32'hACAB_0012);
        idle(2);

        // Store then back-to-back loads (valid never drops), incl. alias.
        run_txn(1, "store_feed", STORE, 32'h0000_0040, 32'hFEED_BEEF, n, fw, er);
        check("store_feed_distance", n - 1, 32'd2);
        run_txn(1, "load_0x43", LOAD, 32'h0000_0043, 32'h0, n, fw, er);
        check("load_0x43_distance", n - 1, 32'd2);
        check("load_0x43_data", fw, 32'hFEED_BEEF);
        run_txn(1, "load_alias", LOAD, 32'h0000_2040, 32'h0, n, fw, er);
        check("load_alias_distance", n - 1, 32'd2);
        check("load_alias_data", fw, 32'hFEED_BEEF);
        run_txn(1, "load_b2b", LOAD, 32'h0000_0100, 32'h0, n, fw, er);
        check("load_b2b_distance", n - 1, 32'd2);
        check("load_b2b_data", fw, 32'hACAB_0012);
        idle(3);

        // Reset during WAIT of a store: no pulse, store not committed.
        valid_v[1] = 1'b1;
        type_v[1]  = STORE;
        addr_v[1]  = 32'h0000_0080;
        data_v[1]  = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        valid_v[1] = 1'b0;
        @(posedge clk); #1;
        check("abort_no_pulse", {31'b0, fulfilled_v[1]}, 32'd0);
        reset = 1'b0;
        idle(3);
        run_txn(1, "load_after_abort", LOAD, 32'h0000_0080, 32'h0, n, fw, er);
        check("load_after_abort_data", fw, 32'hACAB_0012);
        idle(1);

        // Illegal opcode: pulse, sticky error, array untouched.
        run_txn(1, "store_a5", STORE, 32'h0000_0080, 32'hA5A5_5A5A, n, fw, er);
        idle(1);
        run_txn(1, "clflush", CLFLUSH, 32'h0000_0080, 32'hDEAD_DEAD, n, fw, er);
        check("clflush_distance", n - 1, 32'd2);
        check("clflush_error", {31'b0, er}, 32'd1);
        idle(5);
        check("clflush_error_sticky", {31'b0, err_v[1]}, 32'd1);
        run_txn(1, "load_after_flush", LOAD, 32'h0000_0080, 32'h0, n, fw, er);
        check("load_after_flush_data", fw, 32'hA5A5_5A5A);
        check("load_after_flush_error", {31'b0, er}, 32'd1);
        do_reset();
        check("error_cleared_by_reset", {31'b0, err_v[1]}, 32'd0);

        // Other latency builds.
        run_txn(0, "lat1_load", LOAD, 32'h0000_0100, 32'h0, n, fw, er);
        check("lat1_distance", n - 1, 32'd1);
        check("lat1_data", fw, 32'hACAB_0012);
        idle(1);
        run_txn(2, "lat7_store", STORE, 32'h0000_0040, 32'hFEED_BEEF, n, fw, er);
        check("lat7_store_distance", n - 1, 32'd7);
        run_txn(2, "lat7_load", LOAD, 32'h0000_0043, 32'h0, n, fw, er);
        check("lat7_distance", n - 1, 32'd7);
        check("lat7_data", fw, 32'hFEED_BEEF);
        idle(2);

        // Randomized traffic on instance 1, checked by the model.
        for (int t = 0; t < 150; t++) begin
            memory_operation_e op;
            logic [31:0]       a;
            int                r;
            int                rst_at;
            int                k;
            bit                got;
            bit                aborted;
            r = int'($urandom_range(0, 99));
            op = (r < 45) ? LOAD : ((r < 90) ? STORE : ((r < 95) ? CLFLUSH : FENCE));
            a = $urandom;
            a[12:2] = 11'($urandom_range(0, 15));
            rst_at = ($urandom_range(0, 99) < 5) ? int'($urandom_range(1, 2)) : 0;
            valid_v[1] = 1'b1;
            type_v[1]  = op;
            addr_v[1]  = a;
            data_v[1]  = $urandom;
            got = 0;
            aborted = 0;
            k = 0;
            while (!got && !aborted && k < 20) begin
                @(posedge clk); #1;
                k++;
                if (fulfilled_v[1]) begin
                    got = 1;
                end else if (rst_at != 0 && k == rst_at) begin
                    reset = 1'b1;
                    valid_v[1] = 1'b0;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    aborted = 1;
                end else if ($urandom_range(0, 9) < 3) begin
                    // Scribble on held fields: captured values must win.
                    addr_v[1] = $urandom;
                    data_v[1] = $urandom;
                    type_v[1] = memory_operation_e'(2'($urandom_range(0, 3)));
                end
            end
            if (aborted) begin
                $display("txn rnd%0d op=%s addr=%h aborted by reset", t, op.name(), a);
            end else if (!got) begin
                n_checks++;
                n_errors++;
                $display("FAIL rnd_timeout: txn %0d got no pulse in 20 cycles, required one", t);
            end else begin
                $display("txn rnd%0d op=%s addr=%h fetched=%h err=%0d",
                         t, op.name(), a, fetched_v[1], err_v[1]);
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
